// File: rtl/reset_sequencer_if.sv
// reset_sequencer_if: bundle between the reset sequencer and its reset domains.
// master = sequencer side, slave = downstream domains / stimulus side.
interface reset_sequencer_if #(
    parameter int NUM_STAGES = 4
);
    logic                  SoftReset;
    logic [NUM_STAGES-1:0] StageReady;
    logic [NUM_STAGES-1:0] qnStageReset;
    logic                  SeqDone;
    logic                  SeqFault;
    logic [2:0]            FaultStage;
    logic [7:0]            RestartCnt;

    modport master (
        input  SoftReset, StageReady,
        output qnStageReset, SeqDone, SeqFault, FaultStage, RestartCnt
    );

    modport slave (
        output SoftReset, StageReady,
        input  qnStageReset, SeqDone, SeqFault, FaultStage, RestartCnt
    );
endinterface

// File: rtl/reset_sequencer.sv
// reset_sequencer: releases NUM_STAGES reset domains in order, each after the
// previous reports ready; auto re-sequences on ready loss.
// Ports: Clock, qnReset (async active-low), bus (reset_sequencer_if.master):
//   SoftReset, StageReady in; qnStageReset, SeqDone, SeqFault, FaultStage,
//   RestartCnt out.
// Optional: `define RST_SEQ_TIMEOUT_EN adds the ready timeout and FAULT state.
module reset_sequencer #(
    parameter int NUM_STAGES     = 4,
    parameter int HOLD_CYCLES    = 16,
    parameter int STAGE_DELAY    = 8,
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int CNT_WIDTH      = 16
) (
    input  logic              Clock,
    input  logic              qnReset,
    reset_sequencer_if.master bus
);

    localparam int IDX_W = $clog2(NUM_STAGES);
    localparam logic [CNT_WIDTH-1:0] HOLD_LAST = CNT_WIDTH'(HOLD_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] DLY_LAST  = CNT_WIDTH'(STAGE_DELAY - 1);
    localparam logic [CNT_WIDTH-1:0] TO_LAST   = CNT_WIDTH'(TIMEOUT_CYCLES - 1);
    localparam logic [IDX_W-1:0]     IDX_LAST  = IDX_W'(NUM_STAGES - 1);

    typedef enum logic [2:0] {
        HOLD,
        DELAY,
        WAIT_RDY,
        DONE,
        FAULT
    } state_t;

    // Asserts asynchronously, releases two edges after qnReset rises.
    logic [1:0] sync_q;
    logic       srst_n;

    always_ff @(posedge Clock or negedge qnReset) begin
        if (!qnReset) sync_q <= '0;
        else          sync_q <= {sync_q[0], 1'b1};
    end

    assign srst_n = sync_q[1];

    state_t                state_q, state_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [NUM_STAGES-1:0] rst_q, rst_d;
    logic                  done_q, done_d;
    logic [7:0]            rcnt_q, rcnt_d;
`ifdef RST_SEQ_TIMEOUT_EN
    logic                  fault_q, fault_d;
    logic [2:0]            fstage_q, fstage_d;
`endif

    always_ff @(posedge Clock or negedge srst_n) begin
        if (!srst_n) begin
            state_q  <= HOLD;
            cnt_q    <= '0;
            idx_q    <= '0;
            rst_q    <= '0;
            done_q   <= 1'b0;
            rcnt_q   <= '0;
`ifdef RST_SEQ_TIMEOUT_EN
            fault_q  <= 1'b0;
            fstage_q <= '0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            rst_q    <= rst_d;
            done_q   <= done_d;
            rcnt_q   <= rcnt_d;
`ifdef RST_SEQ_TIMEOUT_EN
            fault_q  <= fault_d;
            fstage_q <= fstage_d;
`endif
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        rst_d    = rst_q;
        done_d   = done_q;
        rcnt_d   = rcnt_q;
`ifdef RST_SEQ_TIMEOUT_EN
        fault_d  = fault_q;
        fstage_d = fstage_q;
`endif
        // SoftReset outranks every event of the current state.
        if (bus.SoftReset) begin
            state_d = HOLD;
            cnt_d   = '0;
            idx_d   = '0;
            rst_d   = '0;
            done_d  = 1'b0;
`ifdef RST_SEQ_TIMEOUT_EN
            fault_d = 1'b0;
`endif
        end else begin
            unique case (state_q)
                HOLD: begin
                    if (cnt_q == HOLD_LAST) begin
                        state_d = DELAY;
                        cnt_d   = '0;
                        idx_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                DELAY: begin
                    if (cnt_q == DLY_LAST) begin
                        rst_d[idx_q] = 1'b1;
                        state_d      = WAIT_RDY;
                        cnt_d        = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                WAIT_RDY: begin
                    // Ready is checked first so it wins over timeout expiry.
                    if (bus.StageReady[idx_q]) begin
                        cnt_d = '0;
                        if (idx_q == IDX_LAST) begin
                            state_d = DONE;
                            done_d  = 1'b1;
                        end else begin
                            idx_d   = idx_q + 1'b1;
                            state_d = DELAY;
                        end
`ifdef RST_SEQ_TIMEOUT_EN
                    end else if (cnt_q == TO_LAST) begin
                        state_d  = FAULT;
                        rst_d    = '0;
                        fault_d  = 1'b1;
                        fstage_d = 3'(idx_q);
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
`else
                    end else if (cnt_q != TO_LAST) begin
                        // No fault here; the wait counter just parks.
                        cnt_d = cnt_q + 1'b1;
                    end
`endif
                end
                DONE: begin
                    if (!(&bus.StageReady)) begin
                        state_d = HOLD;
                        cnt_d   = '0;
                        idx_d   = '0;
                        rst_d   = '0;
                        done_d  = 1'b0;
                        if (rcnt_q != 8'hFF) rcnt_d = rcnt_q + 1'b1;
                    end
                end
                FAULT: begin
                    rst_d = '0;
                end
                default: begin
                    state_d = HOLD;
                    cnt_d   = '0;
                    idx_d   = '0;
                    rst_d   = '0;
                    done_d  = 1'b0;
                end
            endcase
        end
    end

    assign bus.qnStageReset = rst_q;
    assign bus.SeqDone      = done_q;
    assign bus.RestartCnt   = rcnt_q;
`ifdef RST_SEQ_TIMEOUT_EN
    assign bus.SeqFault     = fault_q;
    assign bus.FaultStage   = fstage_q;
`else
    assign bus.SeqFault     = 1'b0;
    assign bus.FaultStage   = 3'd0;
`endif

endmodule

// File: tb/tb_reset_sequencer.sv
// tb_reset_sequencer: directed bench for reset_sequencer; downstream stages
// answer ready 3 cycles after their reset is released, with a drop mask.
module tb_reset_sequencer;

    logic       Clock = 1'b0;
    logic       qnReset;
    logic [3:0] d1, d2, d3;
    logic [3:0] mask;
    int         n_cmp = 0;
    int         n_bad = 0;
    int         n;

    always #5 Clock = ~Clock;

    reset_sequencer_if #(.NUM_STAGES(4)) bus ();

    reset_sequencer #(
        .NUM_STAGES    (4),
        .HOLD_CYCLES   (16),
        .STAGE_DELAY   (8),
        .TIMEOUT_CYCLES(1024),
        .CNT_WIDTH     (16)
    ) dut (
        .Clock  (Clock),
        .qnReset(qnReset),
        .bus    (bus)
    );

    always @(posedge Clock) begin
        d1 <= bus.qnStageReset;
        d2 <= d1;
        d3 <= d2;
    end

    assign bus.StageReady = d3 & ~mask;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int k);
        repeat (k) @(posedge Clock);
        #1;
    endtask

    task automatic wait_done(output int cyc);
        cyc = 0;
        while (bus.SeqDone !== 1'b1 && cyc < 400) begin
            tick(1);
            cyc++;
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_rst"},   32'(bus.qnStageReset), 32'h0);
        check({tag, "_done"},  32'(bus.SeqDone),      32'h0);
        check({tag, "_fault"}, 32'(bus.SeqFault),     32'h0);
        check({tag, "_fstg"},  32'(bus.FaultStage),   32'h0);
        check({tag, "_rcnt"},  32'(bus.RestartCnt),   32'h0);
    endtask

    initial begin
        qnReset       = 1'b0;
        bus.SoftReset = 1'b0;
        mask          = 4'b0000;
        tick(5);
        check_all_zero("reset");

        // Power-up: release mid-cycle, edges e1.. counted from here.
        #2 qnReset = 1'b1;
        tick(25);
        check("pu_e25", 32'(bus.qnStageReset), 32'h0);
        tick(1);
        check("pu_e26", 32'(bus.qnStageReset), 32'h1);
        tick(11);
        check("pu_e37", 32'(bus.qnStageReset), 32'h1);
        tick(1);
        check("pu_e38", 32'(bus.qnStageReset), 32'h3);
        tick(12);
        check("pu_e50", 32'(bus.qnStageReset), 32'h7);
        tick(12);
        check("pu_e62", 32'(bus.qnStageReset), 32'hF);
        tick(3);
        check("pu_e65_done", 32'(bus.SeqDone), 32'h0);
        tick(1);
        check("pu_e66_done", 32'(bus.SeqDone), 32'h1);

        // Ready drop for one cycle in DONE.
        mask = 4'b0010;
        tick(1);
        mask = 4'b0000;
        check("drop_rst",  32'(bus.qnStageReset), 32'h0);
        check("drop_done", 32'(bus.SeqDone),      32'h0);
        check("drop_rcnt", 32'(bus.RestartCnt),   32'h1);
        wait_done(n);
        check("drop_reseq_len", 32'(n), 32'd64);

        // SoftReset and ready drop in the same DONE cycle.
        mask          = 4'b0010;
        bus.SoftReset = 1'b1;
        tick(1);
        mask          = 4'b0000;
        bus.SoftReset = 1'b0;
        check("tie_rst",  32'(bus.qnStageReset), 32'h0);
        check("tie_done", 32'(bus.SeqDone),      32'h0);
        check("tie_rcnt", 32'(bus.RestartCnt),   32'h1);
        wait_done(n);
        check("tie_reseq_len", 32'(n), 32'd64);

        // SoftReset from DONE, then again in DELAY of stage 1.
        bus.SoftReset = 1'b1;
        tick(1);
        bus.SoftReset = 1'b0;
        tick(30);
        check("soft_in_dly1", 32'(bus.qnStageReset), 32'h1);
        bus.SoftReset = 1'b1;
        tick(1);
        bus.SoftReset = 1'b0;
        check("soft_rst", 32'(bus.qnStageReset), 32'h0);
        tick(23);
        check("soft_hold23", 32'(bus.qnStageReset), 32'h0);
        tick(1);
        check("soft_hold24", 32'(bus.qnStageReset), 32'h1);
        check("soft_rcnt", 32'(bus.RestartCnt), 32'h1);
        wait_done(n);
        check("soft_done_len", 32'(n), 32'd40);

        // 299 more drops: 300 total restarts saturate at 255.
        for (int i = 0; i < 299; i++) begin
            mask = 4'b0010;
            tick(1);
            mask = 4'b0000;
            wait_done(n);
            if (bus.SeqDone !== 1'b1) check("sat_loop_done", 32'(n), 32'd64);
        end
        check("sat_rcnt", 32'(bus.RestartCnt), 32'd255);
        check("sat_done", 32'(bus.SeqDone),    32'h1);

        // Async reset between clock edges while in DONE.
        #3 qnReset = 1'b0;
        #1 check_all_zero("async");
        #1 qnReset = 1'b1;
        wait_done(n);
        check("async_reseq_len", 32'(n), 32'd66);

        // Stage 2 never ready.
        qnReset = 1'b0;
        tick(2);
        mask = 4'b0100;
        #2 qnReset = 1'b1;
        tick(49);
        check("to_e49", 32'(bus.qnStageReset), 32'h3);
        tick(1);
        check("to_e50", 32'(bus.qnStageReset), 32'h7);
`ifdef RST_SEQ_TIMEOUT_EN
        tick(1023);
        check("to_pre_fault", 32'(bus.SeqFault),     32'h0);
        check("to_pre_rst",   32'(bus.qnStageReset), 32'h7);
        tick(1);
        check("to_fault",  32'(bus.SeqFault),     32'h1);
        check("to_rst",    32'(bus.qnStageReset), 32'h0);
        check("to_fstage", 32'(bus.FaultStage),   32'h2);
        tick(5);
        check("to_sticky", 32'(bus.SeqFault), 32'h1);
        bus.SoftReset = 1'b1;
        mask          = 4'b0000;
        tick(1);
        bus.SoftReset = 1'b0;
        check("to_clear", 32'(bus.SeqFault), 32'h0);
        wait_done(n);
        check("to_reseq_len", 32'(n), 32'd64);
`else
        tick(1100);
        check("nto_fault", 32'(bus.SeqFault),     32'h0);
        check("nto_rst",   32'(bus.qnStageReset), 32'h7);
        check("nto_done",  32'(bus.SeqDone),      32'h0);
        mask = 4'b0000;
        wait_done(n);
        check("nto_done_late", 32'(bus.SeqDone), 32'h1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
